// File: rtl/lfsr_period_engine.sv
// Fibonacci LFSR with runtime seed/taps, free-run or single-step advance,
// zero-state lockup recovery and measurement of the period back to a reference state.
module lfsr_period_engine #(
    parameter int              BITS         = 8,
    parameter int              TICKS        = 1000,
    parameter logic [BITS-1:0] DEFAULT_TAPS = 8'hB8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_seed_i,
    input  logic            load_taps_i,
    input  logic [BITS-1:0] data_i,
    input  logic            run_i,
    input  logic            step_i,
    output logic [BITS-1:0] state_o,
    output logic            step_o,
    output logic [BITS-1:0] period_o,
    output logic            period_valid_o,
    output logic            lockup_o
);

    localparam int              PW         = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICKS - 1);
    localparam logic [BITS-1:0] ONE        = BITS'(1);
    localparam logic [BITS-1:0] ALL_ONES   = '1;

    logic [BITS-1:0] taps;
    logic [BITS-1:0] ref_state;
    logic [BITS-1:0] count;
    logic [PW-1:0]   prescaler;
    logic            step_d;

    logic            fb;
    logic [BITS-1:0] next_raw;
    logic [BITS-1:0] next_state;
    logic [BITS-1:0] seed_val;
    logic            load;
    logic            step_event;

    always_comb begin
        fb         = ^(state_o & taps);
        next_raw   = {state_o[BITS-2:0], fb};
        next_state = (next_raw == '0) ? ONE : next_raw;
        seed_val   = (data_i == '0) ? ONE : data_i;
        load       = load_seed_i | load_taps_i;
        step_event = run_i ? (prescaler == PRESC_LAST) : (step_i & ~step_d);
    end

    // NOTE: all state is updated with non-blocking assignments so every branch below
    // reads the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_o        <= ONE;
            taps           <= DEFAULT_TAPS;
            ref_state      <= ONE;
            count          <= '0;
            period_o       <= '0;
            period_valid_o <= 1'b0;
            lockup_o       <= 1'b0;
            step_o         <= 1'b0;
            prescaler      <= '0;
            step_d         <= 1'b0;
        end else begin
            step_d <= step_i;
            step_o <= 1'b0;
            if (load) begin
                // A load restarts the measurement from the state that will be visible next cycle.
                prescaler      <= '0;
                count          <= '0;
                period_valid_o <= 1'b0;
                lockup_o       <= 1'b0;
                if (load_taps_i)
                    taps <= data_i;
                if (load_seed_i) begin
                    state_o   <= seed_val;
                    ref_state <= seed_val;
                end else begin
                    ref_state <= state_o;
                end
            end else begin
                if (run_i)
                    prescaler <= (prescaler == PRESC_LAST) ? '0 : prescaler + PW'(1);
                else
                    prescaler <= '0;

                if (step_event) begin
                    step_o  <= 1'b1;
                    state_o <= next_state;
                    if (next_raw == '0)
                        lockup_o <= 1'b1;
                    if (next_state == ref_state) begin
                        period_o       <= (count == ALL_ONES) ? ALL_ONES : count + ONE;
                        period_valid_o <= 1'b1;
                        count          <= '0;
                    end else if (count != ALL_ONES) begin
                        count <= count + ONE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_lfsr_period_engine.sv
// Self-checking bench for lfsr_period_engine: directed scenarios plus randomized
// traffic, compared every cycle against a step-counting behavioural model.
module tb_lfsr_period_engine;

    localparam int BITS  = 8;
    localparam int TICKS = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            load_seed_i;
    logic            load_taps_i;
    logic [BITS-1:0] data_i;
    logic            run_i;
    logic            step_i;
    logic [BITS-1:0] state_o;
    logic            step_o;
    logic [BITS-1:0] period_o;
    logic            period_valid_o;
    logic            lockup_o;

    lfsr_period_engine #(.BITS(BITS), .TICKS(TICKS), .DEFAULT_TAPS(8'hB8)) dut (
        .clk            (clk),
        .reset          (reset),
        .load_seed_i    (load_seed_i),
        .load_taps_i    (load_taps_i),
        .data_i         (data_i),
        .run_i          (run_i),
        .step_i         (step_i),
        .state_o        (state_o),
        .step_o         (step_o),
        .period_o       (period_o),
        .period_valid_o (period_valid_o),
        .lockup_o       (lockup_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural model: tracks steps since the reference and cycles of continuous running.
    int unsigned m_state, m_taps, m_ref, m_period;
    int unsigned m_since;
    int unsigned m_run_cycles;
    bit          m_valid, m_lock, m_step, m_prev;

    function automatic int unsigned lfsr_next(input int unsigned s, input int unsigned t);
        int unsigned fb;
        fb = $countones(s & t) % 2;
        return ((s * 2) % 256) + fb;
    endfunction

    task automatic model(input bit rst, input bit ls, input bit lt, input int unsigned d,
                         input bit run, input bit st);
        bit          fire;
        int unsigned nxt;
        if (rst) begin
            m_state = 1; m_taps = 'hB8; m_ref = 1; m_period = 0; m_since = 0;
            m_run_cycles = 0; m_valid = 0; m_lock = 0; m_step = 0; m_prev = 0;
            return;
        end
        fire   = !(ls || lt) && (run ? (m_run_cycles % TICKS == TICKS - 1) : (st && !m_prev));
        m_prev = st;
        m_step = fire;
        m_run_cycles = (ls || lt || !run) ? 0 : m_run_cycles + 1;
        if (ls || lt) begin
            if (ls) m_state = (d == 0) ? 1 : d;
            if (lt) m_taps = d;
            m_ref = m_state; m_since = 0; m_valid = 0; m_lock = 0;
        end else if (fire) begin
            nxt = lfsr_next(m_state, m_taps);
            if (nxt == 0) begin
                nxt = 1;
                m_lock = 1;
            end
            m_state = nxt;
            m_since++;
            if (m_state == m_ref) begin
                m_period = (m_since > 255) ? 255 : m_since;
                m_valid  = 1;
                m_since  = 0;
            end
        end
    endtask

    // One clock: apply inputs, advance the model, sample 1 time unit after the edge.
    task automatic tick(input bit rst, input bit ls, input bit lt, input int unsigned d,
                        input bit run, input bit st);
        reset = rst; load_seed_i = ls; load_taps_i = lt; data_i = d[7:0]; run_i = run; step_i = st;
        model(rst, ls, lt, d, run, st);
        @(posedge clk);
        #1;
        check("state",  state_o,        m_state);
        check("step",   step_o,         m_step);
        check("period", period_o,       m_period);
        check("valid",  period_valid_o, m_valid);
        check("lockup", lockup_o,       m_lock);
    endtask

    task automatic full_period_run(input string tag);
        int steps;
        steps = 0;
        repeat (255) begin
            tick(0, 0, 0, 0, 0, 1); steps += int'(step_o);
            tick(0, 0, 0, 0, 0, 0); steps += int'(step_o);
        end
        check({tag, "_steps"},  steps,          255);
        check({tag, "_state"},  state_o,        8'h01);
        check({tag, "_period"}, period_o,       8'd255);
        check({tag, "_valid"},  period_valid_o, 1'b1);
    endtask

    initial begin
        int          steps;
        int unsigned exp_state;
        bit          run, st;

        // Reset state
        tick(1, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
        check("rst_state", state_o, 8'h01);
        check("rst_valid", period_valid_o, 1'b0);
        tick(0, 0, 0, 0, 0, 0);

        // Maximal-length sequence returns to 1 after 255 single steps
        full_period_run("s1");

        // Zero seed becomes 1
        tick(0, 1, 0, 8'h00, 0, 0);
        check("s2_state", state_o, 8'h01);
        check("s2_lock",  lockup_o, 1'b0);
        check("s2_valid", period_valid_o, 1'b0);

        // Zero taps: walking one, then lockup recovery back to the reference
        tick(0, 0, 1, 8'h00, 0, 0);
        for (int i = 0; i < 8; i++) begin
            tick(0, 0, 0, 0, 0, 1);
            exp_state = (i < 7) ? (1 << (i + 1)) : 1;
            check("s3_walk", state_o, exp_state);
            check("s3_lock", lockup_o, (i == 7) ? 1'b1 : 1'b0);
            tick(0, 0, 0, 0, 0, 0);
        end
        check("s3_period", period_o, 8'd8);
        check("s3_valid",  period_valid_o, 1'b1);
        tick(0, 0, 1, 8'hB8, 0, 0);

        // Free run: one step every TICKS cycles, step_i ignored
        steps = 0;
        for (int i = 0; i < 10 * TICKS; i++) begin
            tick(0, 0, 0, 0, 1, 1'($urandom));
            steps += int'(step_o);
        end
        check("s4_steps", steps, 10);

        // Load during free run at prescaler=2
        while (m_run_cycles % TICKS != 2) tick(0, 0, 0, 0, 1, 0);
        tick(0, 1, 0, 8'h5A, 1, 0);
        check("s5_state", state_o, 8'h5A);
        check("s5_nostep", step_o, 1'b0);
        for (int i = 1; i <= TICKS; i++) begin
            tick(0, 0, 0, 0, 1, 0);
            check("s5_step", step_o, (i == TICKS) ? 1'b1 : 1'b0);
        end
        check("s5_next", state_o, lfsr_next(8'h5A, 8'hB8));

        // Reset mid-measurement, then a clean re-run
        tick(0, 1, 0, 8'h01, 0, 0);
        repeat (100) begin
            tick(0, 0, 0, 0, 0, 1);
            tick(0, 0, 0, 0, 0, 0);
        end
        tick(1, 0, 0, 0, 0, 0);
        check("s6_state", state_o, 8'h01);
        check("s6_valid", period_valid_o, 1'b0);
        check("s6_lock",  lockup_o, 1'b0);
        tick(0, 0, 0, 0, 0, 0);
        full_period_run("s6");

        // Randomized traffic against the model
        run = 0;
        st  = 0;
        for (int i = 0; i < 3000; i++) begin
            int unsigned r;
            r = $urandom_range(0, 999);
            if ($urandom_range(0, 99) < 2) run = ~run;
            if ($urandom_range(0, 2) == 0) st = ~st;
            if (r < 3)
                tick(1, 0, 0, 0, run, st);
            else if (r < 25)
                tick(0, 1'($urandom), 1'($urandom), $urandom_range(0, 255), run, st);
            else
                tick(0, 0, 0, 0, run, st);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
